idmem_arbiter: RTL and testbench
================================

# idmem_arbiter

Two-requester arbiter sharing the single-port instruction/data memory between the multi-cycle CPU core and a loader/debug port (program download, memory inspection). One access is issued per cycle: it muxes address/write data/write-enable into the memory and routes the synchronous read data back to the requester that issued the read. The CPU stalls while its request is not granted. A bounded loader lock supports burst programming without starving the core.

## Interface
- `AW`, 32: address width.
- `DW`, 32: data width.
- `LDR_MAX_BEATS`, 8: max consecutive locked loader grants while the CPU is waiting (≥1).

- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cpu_req`  in  1  CPU access request.
- `cpu_we`  in  1  CPU write (1) / read (0).
- `cpu_addr`  in  AW  CPU byte address.
- `cpu_wdata`  in  DW  CPU write data.
- `cpu_gnt`  out  1  CPU access issued this cycle.
- `cpu_stall`  out  1  `cpu_req & ~cpu_gnt`.
- `cpu_rvalid`  out  1  CPU read data valid.
- `cpu_rdata`  out  DW  CPU read data.
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata`, `ldr_gnt`, `ldr_rvalid`, `ldr_rdata`: same as CPU set, loader side.
- `ldr_lock`  in  1  loader requests burst ownership.
- `mem_addr`  out  AW  memory address.
- `mem_we`  out  1  memory write enable.
- `mem_wd`  out  DW  memory write data.
- `mem_rd`  in  DW  memory read data, valid the cycle after the read address.

## Operation
- State: `owner_q` ∈ {NONE, CPU, LDR}, last granted requester; `beat_cnt` (0..LDR_MAX_BEATS), consecutive loader grants since last CPU grant; `rtag_q` ∈ {NONE, CPU, LDR}, issuer of the read in flight.
- Grant (combinational, same cycle as request):
  - One requester: it is granted.
  - Both, and `owner_q==LDR & ldr_lock & beat_cnt<LDR_MAX_BEATS`: loader.
  - Both, otherwise: round-robin, requester ≠ `owner_q`. `owner_q==NONE` → CPU.
  - Neither: no grant. `mem_we=0`. `mem_addr` and `mem_wd` hold the CPU inputs (don't-care).
- The granted requester's addr/wdata/we drive the memory. `mem_we` is high only in a granted write cycle.
- On grant: `owner_q` ← winner. CPU grant: `beat_cnt` ← 0. Loader grant: `beat_cnt` ← `beat_cnt+1`, saturating at LDR_MAX_BEATS. No grant: both hold.
- `rtag_q` ← winner if the granted access is a read, else NONE.
- Next cycle: `rvalid` of the tagged requester = 1. Both `cpu_rdata` and `ldr_rdata` = `mem_rd` (passthrough, qualified by rvalid).
- Writes never produce rvalid.

## Timing
- Grant: 0-cycle latency. Read data: 1 cycle after grant. Back-to-back reads from either side at full rate, so a read response and a new grant coexist in one cycle.
- A requester must hold req/we/addr/wdata stable until granted. Deasserting req before grant is legal (request withdrawn).
- Reset (any cycle, including mid-read): `owner_q=NONE`, `beat_cnt=0`, `rtag_q=NONE`. In the cycle `rst` is high, grants, `mem_we`, `cpu_stall` and rvalids are 0. Next cycle, rvalids are 0; an in-flight read is dropped.
- `ldr_lock` without `ldr_req` has no effect. Lock with CPU idle lets the loader be granted indefinitely.
- Worst-case CPU wait with lock: LDR_MAX_BEATS cycles.

## Structure
- Package `idmem_arb_pkg`: `owner_e` enum {OWN_NONE, OWN_CPU, OWN_LDR}, shared by the arbiter and the testbench.
- No sub-module. Grant logic is a single `always_comb`. State is one `always_ff`.
- Top-level integration: the CPU top inserts this block between its address/write-data muxes and the memory. The CPU's `cpu_stall` gates `pc_write`/`ir_write` and the control FSM advance.

## Test plan
- Reset: hold `rst` 2 cycles with both reqs high → all grants, rvalids, `mem_we`, `cpu_stall` = 0. After release, first contended cycle grants CPU.
- CPU read alone: `cpu_addr=0x10`, memory word 0xDEADBEEF → `cpu_gnt=1` same cycle, `mem_addr=0x10`. Next cycle `cpu_rvalid=1`, `cpu_rdata=0xDEADBEEF`, `ldr_rvalid=0`.
- Contention, no lock: both request continuously for 6 cycles → grants CPU, LDR, CPU, LDR, CPU, LDR. `cpu_stall` high on LDR cycles.
- Lock burst, LDR_MAX_BEATS=4: loader granted first with lock, CPU requesting → 4 consecutive loader grants, then CPU grant, then loader again (`beat_cnt` cleared).
- Loader write 0x0000_0042 to 0x20 → `mem_we=1` only in grant cycle, no `ldr_rvalid`. CPU read of 0x20 afterwards returns 0x42.
- Reset mid-read: CPU read granted, `rst` asserted next cycle → `cpu_rvalid=0` in that cycle and the one after.

Source files
------------

// File: rtl/idmem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
// Owner/tag encoding is common to the RTL and the bench.
package idmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_LDR  = 2'd2
  } owner_e;

endpackage

// File: rtl/idmem_arbiter.sv
// Single-port memory arbiter: CPU core vs loader/debug port.
// Zero-latency grant, 1-cycle read return, bounded loader lock.
module idmem_arbiter
  import idmem_arb_pkg::*;
#(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int LDR_MAX_BEATS = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  input  logic          ldr_lock,
  output logic          ldr_gnt,
  output logic          ldr_rvalid,
  output logic [DW-1:0] ldr_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  localparam int BW = $clog2(LDR_MAX_BEATS + 1);
  localparam logic [BW-1:0] MAXB = BW'(LDR_MAX_BEATS);

  owner_e        owner_q;
  owner_e        rtag_q;
  owner_e        win;
  logic [BW-1:0] beat_cnt;
  logic          both;
  logic          hold_ldr;
  logic          sel_we;

  assign both     = cpu_req & ldr_req;
  assign hold_ldr = (owner_q == OWN_LDR) & ldr_lock
                  & (beat_cnt < MAXB);

  always_comb begin
    win = OWN_NONE;
    unique case (1'b1)
      rst: win = OWN_NONE;
      ~rst & cpu_req & ~ldr_req: win = OWN_CPU;
      ~rst & ldr_req & ~cpu_req: win = OWN_LDR;
      ~rst & both & hold_ldr:    win = OWN_LDR;
      // round-robin: the side that did not win last time
      ~rst & both & ~hold_ldr:
        win = (owner_q == OWN_CPU) ? OWN_LDR : OWN_CPU;
      default: win = OWN_NONE;
    endcase
  end

  assign cpu_gnt   = (win == OWN_CPU);
  assign ldr_gnt   = (win == OWN_LDR);
  assign cpu_stall = cpu_req & ~cpu_gnt & ~rst;

  assign sel_we   = ldr_gnt ? ldr_we : cpu_we;
  assign mem_addr = ldr_gnt ? ldr_addr : cpu_addr;
  assign mem_wd   = ldr_gnt ? ldr_wdata : cpu_wdata;
  assign mem_we   = (cpu_gnt | ldr_gnt) & sel_we;

  assign cpu_rvalid = (rtag_q == OWN_CPU) & ~rst;
  assign ldr_rvalid = (rtag_q == OWN_LDR) & ~rst;
  assign cpu_rdata  = mem_rd;
  assign ldr_rdata  = mem_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q  <= OWN_NONE;
      rtag_q   <= OWN_NONE;
      beat_cnt <= '0;
    end else begin
      rtag_q <= OWN_NONE;
      if (win != OWN_NONE) begin
        owner_q <= win;
        if (!sel_we)
          rtag_q <= win;
      end
      if (win == OWN_CPU)
        beat_cnt <= '0;
      else if (win == OWN_LDR && beat_cnt < MAXB)
        beat_cnt <= beat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_idmem_arbiter.sv
// Directed bench for idmem_arbiter with a small synchronous memory.
// LDR_MAX_BEATS is 4 so the lock bound is reachable quickly.
module tb_idmem_arbiter;
  import idmem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, ldr_req, ldr_we, ldr_lock;
  logic [31:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid, ldr_gnt, ldr_rvalid;
  logic [31:0] cpu_rdata, ldr_rdata, mem_addr, mem_wd, mem_rd;
  logic        mem_we;
  logic [31:0] mem [0:63];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  idmem_arbiter #(
    .AW(32), .DW(32), .LDR_MAX_BEATS(4)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we),
    .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_lock(ldr_lock), .ldr_gnt(ldr_gnt),
    .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // preload two words while reset is held
  always @(posedge clk) begin
    if (rst) begin
      mem[4] <= 32'hDEAD_BEEF;
      mem[5] <= 32'h1111_2222;
    end else if (mem_we) begin
      mem[mem_addr[7:2]] <= mem_wd;
    end
    mem_rd <= mem[mem_addr[7:2]];
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] gv(input owner_e w);
    return {w == OWN_CPU, w == OWN_LDR};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0;
    ldr_req = 0; ldr_we = 0; ldr_lock = 0;
  endtask

  owner_e ctab [6];
  owner_e ltab [6];
  owner_e prev;

  initial begin
    rst = 1;
    cpu_req = 1; cpu_we = 1;
    cpu_addr = 32'h10; cpu_wdata = 32'h99;
    ldr_req = 1; ldr_we = 0; ldr_lock = 0;
    ldr_addr = 32'h14; ldr_wdata = 0;
    for (int i = 0; i < 2; i++) begin
      tick(); settle();
      chk("rst_gnt", {cpu_gnt, ldr_gnt}, 2'b00);
      chk("rst_we", mem_we, 1'b0);
      chk("rst_stall", cpu_stall, 1'b0);
      chk("rst_rv", {cpu_rvalid, ldr_rvalid}, 2'b00);
    end

    tick(); rst = 0; cpu_we = 0; settle();
    chk("first_cont", {cpu_gnt, ldr_gnt}, gv(OWN_CPU));
    chk("first_stall", cpu_stall, 1'b0);

    tick(); idle(); settle();
    chk("first_rv", {cpu_rvalid, ldr_rvalid}, 2'b10);
    chk("first_rd", cpu_rdata, 32'hDEAD_BEEF);

    tick(); cpu_req = 1; cpu_addr = 32'h10; settle();
    chk("cpu_rd_gnt", cpu_gnt, 1'b1);
    chk("cpu_rd_addr", mem_addr, 32'h10);
    tick(); idle(); settle();
    chk("cpu_rd_rv", {cpu_rvalid, ldr_rvalid}, 2'b10);
    chk("cpu_rd_data", cpu_rdata, 32'hDEAD_BEEF);

    tick(); ldr_req = 1; ldr_addr = 32'h14; settle();
    chk("ldr_rd_gnt", {cpu_gnt, ldr_gnt}, gv(OWN_LDR));
    chk("ldr_rd_addr", mem_addr, 32'h14);
    tick(); idle(); settle();
    chk("ldr_rd_rv", {cpu_rvalid, ldr_rvalid}, 2'b01);
    chk("ldr_rd_data", ldr_rdata, 32'h1111_2222);

    // last owner is LDR, so contention starts with CPU
    ctab = '{OWN_CPU, OWN_LDR, OWN_CPU, OWN_LDR, OWN_CPU, OWN_LDR};
    prev = OWN_NONE;
    tick(); cpu_req = 1; ldr_req = 1;
    for (int i = 0; i < 6; i++) begin
      settle();
      chk($sformatf("rr_gnt%0d", i), {cpu_gnt, ldr_gnt}, gv(ctab[i]));
      chk($sformatf("rr_stall%0d", i), cpu_stall, ctab[i] == OWN_LDR);
      if (i > 0)
        chk($sformatf("rr_rv%0d", i), {cpu_rvalid, ldr_rvalid}, gv(prev));
      prev = ctab[i];
      tick();
    end
    idle(); settle();
    chk("rr_rv_last", {cpu_rvalid, ldr_rvalid}, 2'b01);

    tick(); cpu_req = 1; cpu_we = 1;
    cpu_addr = 32'h30; cpu_wdata = 32'h55; settle();
    chk("cpu_wr_gnt", cpu_gnt, 1'b1);
    chk("cpu_wr_we", mem_we, 1'b1);
    chk("cpu_wr_wd", mem_wd, 32'h55);
    tick(); idle(); settle();
    chk("cpu_wr_norv", {cpu_rvalid, ldr_rvalid}, 2'b00);
    chk("cpu_wr_we_off", mem_we, 1'b0);

    // lock burst: 4 loader beats total, then CPU, then loader
    ltab = '{OWN_LDR, OWN_LDR, OWN_LDR, OWN_LDR, OWN_CPU, OWN_LDR};
    tick(); ldr_req = 1; ldr_lock = 1;
    cpu_addr = 32'h10; ldr_addr = 32'h14;
    for (int i = 0; i < 6; i++) begin
      settle();
      chk($sformatf("lock_gnt%0d", i), {cpu_gnt, ldr_gnt}, gv(ltab[i]));
      tick();
      cpu_req = 1;
    end
    idle();

    tick(); ldr_req = 1; ldr_we = 1;
    ldr_addr = 32'h20; ldr_wdata = 32'h42; settle();
    chk("ldr_wr_gnt", ldr_gnt, 1'b1);
    chk("ldr_wr_we", mem_we, 1'b1);
    chk("ldr_wr_addr", mem_addr, 32'h20);
    tick(); idle(); settle();
    chk("ldr_wr_norv", ldr_rvalid, 1'b0);
    chk("ldr_wr_we_off", mem_we, 1'b0);

    tick(); cpu_req = 1; cpu_addr = 32'h20; settle();
    chk("rb_gnt", cpu_gnt, 1'b1);
    tick(); idle(); settle();
    chk("rb_rv", cpu_rvalid, 1'b1);
    chk("rb_data", cpu_rdata, 32'h42);

    tick(); cpu_req = 1; ldr_lock = 1; cpu_addr = 32'h10; settle();
    chk("lock_noreq", {cpu_gnt, ldr_gnt}, gv(OWN_CPU));

    tick(); rst = 1; ldr_lock = 0; settle();
    chk("mid_rst_rv", cpu_rvalid, 1'b0);
    chk("mid_rst_gnt", cpu_gnt, 1'b0);
    chk("mid_rst_stall", cpu_stall, 1'b0);
    tick(); rst = 0; idle(); settle();
    chk("post_rst_rv", {cpu_rvalid, ldr_rvalid}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
